knight_rider_gen: RTL and testbench

- Generates the 8-bit "knight rider" bouncing-light pattern consumed by the ALU output multiplexer on its knight-rider input (select code 4'b1100).
- A programmable prescaler produces a step tick. On each tick a lit position walks toward the MSB, reverses at bit WIDTH-1, walks back to bit 0, and reverses again.
- An optional trail mode also lights the previous position.
- The block is purely upstream of the mux and has no dependency on the other ALU result buses.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 44 ++++
 rtl/knight_rider_gen.sv | 108 ++++++++++
 tb/tb_knight_rider_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants: mux select codes, data width, direction encoding
package alu_pkg;

    localparam int ALU_W = 8;

    // Result mux select codes
    localparam logic [3:0] SEL_ADD    = 4'b0000;
    localparam logic [3:0] SEL_SUB    = 4'b0001;
    localparam logic [3:0] SEL_AND    = 4'b0010;
    localparam logic [3:0] SEL_OR     = 4'b0011;
    localparam logic [3:0] SEL_XOR    = 4'b0100;
    localparam logic [3:0] SEL_NOT    = 4'b0101;
    localparam logic [3:0] SEL_SHL    = 4'b0110;
    localparam logic [3:0] SEL_SHR    = 4'b0111;
    localparam logic [3:0] SEL_KNIGHT = 4'b1100;

    // Bouncing-light direction encoding
    localparam logic DIR_LEFT  = 1'b0;   // walking toward the MSB
    localparam logic DIR_RIGHT = 1'b1;   // walking toward the LSB

    typedef enum logic {
        KR_LEFT  = DIR_LEFT,
        KR_RIGHT = DIR_RIGHT
    } kr_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - enable-gated modulo-DIV step strobe generator
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   en   - count enable; count holds while low
//   tick - combinational step strobe, high during the cycle whose rising edge
//          wraps the count (en high and count at DIV-1). Consumers register it
//          so their state and their registered tick update on the same edge.
module tick_prescaler #(
    parameter int DIV   = 5000000,
    parameter int CNT_W = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Dropping en on the wrap edge leaves the count parked at DIV-1, so the
    // step fires on the first edge after en returns.
    assign tick = en && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/knight_rider_gen.sv
// rtl/knight_rider_gen.sv - bouncing-light pattern generator for the ALU knight-rider mux input
//
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   en      - run enable (ALU select == SEL_KNIGHT)
//   trail   - 0: single dot, 1: dot plus previous position
//   pattern - registered WIDTH-bit light pattern
//   dir     - registered direction (DIR_LEFT toward MSB, DIR_RIGHT toward LSB)
//   tick    - registered one-cycle pulse on each step
module knight_rider_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DIV   = 5000000,
    parameter int CNT_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trail,
    output logic [WIDTH-1:0] pattern,
    output logic             dir,
    output logic             tick
);

    localparam int POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

    kr_state_e         state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  prev_q, prev_d;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic              tick_q;
    logic              step;

    function automatic logic [WIDTH-1:0] onehot(input logic [POS_W-1:0] p);
        return LSB_ONE << p;
    endfunction

    tick_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (step)
    );

    // Next-state: everything advances only on the wrap edge. The pattern is
    // built from the post-step positions so it lands together with tick, and
    // trail is sampled only here so it never alters the pattern mid-step.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        prev_d    = prev_q;
        pattern_d = pattern_q;
        if (step) begin
            prev_d = pos_q;
            case (state_q)
                KR_LEFT: begin
                    if (pos_q == POS_MAX) begin
                        state_d = KR_RIGHT;
                        pos_d   = POS_MAX - POS_W'(1);
                    end else begin
                        pos_d   = pos_q + POS_W'(1);
                    end
                end
                KR_RIGHT: begin
                    if (pos_q == '0) begin
                        state_d = KR_LEFT;
                        pos_d   = POS_W'(1);
                    end else begin
                        pos_d   = pos_q - POS_W'(1);
                    end
                end
                default: begin
                    state_d = KR_LEFT;
                    pos_d   = '0;
                end
            endcase
            pattern_d = onehot(pos_d) | (trail ? onehot(prev_d) : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= KR_LEFT;
            pos_q     <= '0;
            prev_q    <= '0;
            pattern_q <= LSB_ONE;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            prev_q    <= prev_d;
            pattern_q <= pattern_d;
            tick_q    <= step;
        end
    end

    assign pattern = pattern_q;
    assign dir     = (state_q == KR_RIGHT) ? DIR_RIGHT : DIR_LEFT;
    assign tick    = tick_q;

endmodule

// File: tb/tb_knight_rider_gen.sv
// tb/tb_knight_rider_gen.sv - randomized self-checking bench for knight_rider_gen (DIV=4 and DIV=1)
module tb_knight_rider_gen;

    localparam int W = 8;
    localparam int P = 2 * (W - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic trail = 1'b0;

    logic [W-1:0] pat4, pat1;
    logic         dir4, dir1, tick4, tick1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: enabled-cycle counts, step counts, trail seen at last step
    int   cnt4, k4, cnt1, k1;
    logic tr4, tr1, et4, et1;

    always #5 clk = ~clk;

    knight_rider_gen #(.WIDTH(W), .DIV(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .en(en), .trail(trail),
        .pattern(pat4), .dir(dir4), .tick(tick4)
    );

    knight_rider_gen #(.WIDTH(W), .DIV(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .trail(trail),
        .pattern(pat1), .dir(dir1), .tick(tick1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Position after k steps of a bounce across W lights: 0,1,..,W-1,W-2,..,1,0,1,..
    function automatic int pos_of(input int k);
        int m;
        m = k % P;
        return (m <= W - 1) ? m : P - m;
    endfunction

    function automatic logic [31:0] exp_pat(input int k, input logic tr);
        logic [31:0] p;
        if (k == 0) return 32'h1;
        p = 32'h1 << pos_of(k);
        if (tr) p = p | (32'h1 << pos_of(k - 1));
        return p;
    endfunction

    // Heading toward the LSB from the step after the MSB visit through the step landing on 0
    function automatic logic [31:0] exp_dir(input int k);
        int m;
        m = k % P;
        return {31'b0, (k > 0) && (m == 0 || m >= W)};
    endfunction

    task automatic model_reset();
        cnt4 = 0; k4 = 0; tr4 = 1'b0; et4 = 1'b0;
        cnt1 = 0; k1 = 0; tr1 = 1'b0; et1 = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (en) begin
            cnt4++;
            et4 = 1'b0;
            if (cnt4 == 4) begin
                cnt4 = 0; k4++; tr4 = trail; et4 = 1'b1;
            end
            cnt1 = 0; k1++; tr1 = trail; et1 = 1'b1;
        end else begin
            et4 = 1'b0;
            et1 = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("pattern_div4", {24'b0, pat4}, exp_pat(k4, tr4));
        chk("dir_div4",     {31'b0, dir4}, exp_dir(k4));
        chk("tick_div4",    {31'b0, tick4}, {31'b0, et4});
        chk("pattern_div1", {24'b0, pat1}, exp_pat(k1, tr1));
        chk("dir_div1",     {31'b0, dir1}, exp_dir(k1));
        chk("tick_div1",    {31'b0, tick1}, {31'b0, et1});
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int n;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) run_cycle();

        // First tick latency from the first enabled edge
        rst = 1'b0; en = 1'b1; trail = 1'b0;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (!tick4 && n < 20);
        chk("first_tick_latency", n, 4);

        // Full single-dot sweep past one period
        for (int i = 0; i < 200 && k4 < 16; i++) run_cycle();
        chk("sweep_reached", k4, 16);

        // Pause mid-step with the prescaler at 2, then resume
        for (int i = 0; i < 20 && cnt4 != 2; i++) run_cycle();
        en = 1'b0;
        repeat (10) run_cycle();
        en = 1'b1;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (!tick4 && n < 10);
        chk("resume_latency", n, 2);

        // en dropped on the wrap edge cancels the step; it fires on the first edge back
        for (int i = 0; i < 20 && cnt4 != 3; i++) run_cycle();
        en = 1'b0;
        repeat (3) run_cycle();
        en = 1'b1;
        run_cycle();
        chk("wrap_cancel_resume_tick", {31'b0, tick4}, 32'h1);

        // Trail mode from reset
        rst = 1'b1;
        run_cycle();
        rst = 1'b0; trail = 1'b1;
        for (int i = 0; i < 200 && k4 < 10; i++) run_cycle();

        // Async reset while at 8'h40 heading toward the LSB in single mode
        trail = 1'b0;
        for (int i = 0; i < 300 && !((k4 % P) == 8 && !tr4 && cnt4 == 1); i++) run_cycle();
        chk("pre_reset_pattern", {24'b0, pat4}, 32'h40);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) run_cycle();
        rst = 1'b0;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (!tick4 && n < 20);
        chk("post_reset_tick_latency", n, 4);

        // Randomized enable/trail with occasional synchronous-looking reset pulses
        repeat (700) begin
            en    = ($urandom_range(0, 3) != 0);
            trail = $urandom_range(0, 1) == 1;
            rst   = ($urandom_range(0, 149) == 0);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
